// File: rtl/joystick_pkg.sv
// Shared constants and frame builder for the joystick shift-register responder.
package joystick_pkg;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned SYNC_STAGES = 2;

    // Button positions inside the joy1/joy2 input bytes
    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_FIRE1 = 4;
    localparam int unsigned BTN_FIRE2 = 5;

    // Position of each button in the serial frame (bit 0 leaves first)
    localparam int unsigned J2_FIRE2_BIT = 2;
    localparam int unsigned J2_FIRE1_BIT = 3;
    localparam int unsigned J2_RIGHT_BIT = 4;
    localparam int unsigned J2_LEFT_BIT  = 5;
    localparam int unsigned J2_DOWN_BIT  = 6;
    localparam int unsigned J2_UP_BIT    = 7;
    localparam int unsigned J1_FIRE2_BIT = 10;
    localparam int unsigned J1_FIRE1_BIT = 11;
    localparam int unsigned J1_RIGHT_BIT = 12;
    localparam int unsigned J1_LEFT_BIT  = 13;
    localparam int unsigned J1_DOWN_BIT  = 14;
    localparam int unsigned J1_UP_BIT    = 15;

    // Builds the parallel-load image; unused slots (0,1,8,9) read as 1, buttons are active-low
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] joy1,
                                                          input logic [7:0] joy2);
        logic [FRAME_BITS-1:0] f;
        f               = '1;
        f[J2_FIRE2_BIT] = ~joy2[BTN_FIRE2];
        f[J2_FIRE1_BIT] = ~joy2[BTN_FIRE1];
        f[J2_RIGHT_BIT] = ~joy2[BTN_RIGHT];
        f[J2_LEFT_BIT]  = ~joy2[BTN_LEFT];
        f[J2_DOWN_BIT]  = ~joy2[BTN_DOWN];
        f[J2_UP_BIT]    = ~joy2[BTN_UP];
        f[J1_FIRE2_BIT] = ~joy1[BTN_FIRE2];
        f[J1_FIRE1_BIT] = ~joy1[BTN_FIRE1];
        f[J1_RIGHT_BIT] = ~joy1[BTN_RIGHT];
        f[J1_LEFT_BIT]  = ~joy1[BTN_LEFT];
        f[J1_DOWN_BIT]  = ~joy1[BTN_DOWN];
        f[J1_UP_BIT]    = ~joy1[BTN_UP];
        return f;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous host pin, with registered level and
// a transition strobe taken from one extra flop behind the synchronized level.
module sync_edge
    import joystick_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetN,
    input  logic i_pin,
    output logic o_level,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    // Synchronizer chain plus history flop for edge detection
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_edge  = r_last ^ r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/joystick_sr.sv
// Device side of the serial joystick link: behaves like the external 74HC165 board,
// returning two 6-button joysticks on joyQ under host joyCk/joyLd control.
module joystick_sr
    import joystick_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    input  logic       joyCk,
    input  logic       joyLd,
    output logic       joyQ,
    output logic       linked
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    logic                  w_ck_level;
    logic                  w_ck_edge;
    logic                  w_ld_level;
    logic                  w_ld_edge;
    logic                  w_ck_fall;
    logic                  w_shift;
    logic                  w_complete;
    logic [FRAME_BITS-1:0] w_sr_d;
    logic [CNT_W-1:0]      w_cnt_d;
    logic [WD_W-1:0]       w_wd_inc;
    logic [WD_W-1:0]       w_wd_d;
    logic                  w_linked_d;

    logic [FRAME_BITS-1:0] r_sr;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [WD_W-1:0]       r_wd;
    logic                  r_linked;

    sync_edge #(
        .RESET_VAL (1'b0)
    ) u_ck_sync (
        .clock   (clock),
        .resetN  (resetN),
        .i_pin   (joyCk),
        .o_level (w_ck_level),
        .o_edge  (w_ck_edge)
    );

    sync_edge #(
        .RESET_VAL (1'b1)
    ) u_ld_sync (
        .clock   (clock),
        .resetN  (resetN),
        .i_pin   (joyLd),
        .o_level (w_ld_level),
        .o_edge  (w_ld_edge)
    );

    assign w_ck_fall = w_ck_edge & ~w_ck_level;
    // A fall arriving in the same clock Ld goes high is dropped: Ld must already have been high
    assign w_shift   = w_ck_fall & w_ld_level & ~w_ld_edge;

    // Shift register and bit counter: level load dominates, otherwise shift on Ck fall
    always_comb begin
        w_sr_d     = r_sr;
        w_cnt_d    = r_bit_cnt;
        w_complete = 1'b0;
        if (!w_ld_level) begin
            w_sr_d  = build_frame(joy1, joy2);
            w_cnt_d = '0;
        end else if (w_shift) begin
            w_sr_d     = {1'b1, r_sr[FRAME_BITS-1:1]};
            w_complete = (r_bit_cnt == CNT_LAST);
            if (r_bit_cnt != CNT_MAX) begin
                w_cnt_d = r_bit_cnt + 1'b1;
            end
        end
    end

    // Watchdog and link flag: completion clears the count and wins over a timeout hit
    always_comb begin
        w_wd_inc   = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
        w_wd_d     = w_wd_inc;
        w_linked_d = r_linked;
        if (w_complete) begin
            w_wd_d     = '0;
            w_linked_d = 1'b1;
        end else if (w_wd_inc == WD_MAX) begin
            w_linked_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sr      <= '1;
            r_bit_cnt <= '0;
            r_wd      <= '0;
            r_linked  <= 1'b0;
        end else begin
            r_sr      <= w_sr_d;
            r_bit_cnt <= w_cnt_d;
            r_wd      <= w_wd_d;
            r_linked  <= w_linked_d;
        end
    end

    assign joyQ   = r_sr[0];
    assign linked = r_linked;

endmodule
